iq_demod_accum: RTL

//  Synchronous I/Q demodulator consuming the in-phase/quadrature reference clocks (IP, QP) of
//  the impedance-measurement counter. Enables that counter, aligns to the first IP rising edge,
//  and over NUM_PERIODS reference periods accumulates signed ADC samples. Each sample is

---
 rtl/iq_demod_accum_pkg.sv | 18 +
 rtl/iq_demod_accum_sat_accum.sv | 53 +++++
 rtl/iq_demod_accum.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/iq_demod_accum_pkg.sv
// Shared types for the I/Q demodulator: FSM state encoding, sample-counter
// width and the saturating sample-count increment.
package iq_demod_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NSW = 16;

  function automatic logic [NSW-1:0] sat_inc(input logic [NSW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/iq_demod_accum_sat_accum.sv
// Signed saturating accumulator: adds or subtracts a DW-bit sample into an
// AW-bit register, clamping at the signed limits and flagging each clamp.
module iq_demod_accum_sat_accum #(
  parameter int AW = 24,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          add_i,
  input  logic [DW-1:0] din_i,
  output logic [AW-1:0] acc_o,
  output logic          sat_o
);

  logic [AW-1:0] acc_q, acc_d;
  logic [DW:0]   din_ext;
  logic [DW:0]   term;
  logic [AW:0]   term_ext;
  logic [AW:0]   sum;
  logic          over;
  logic [AW-1:0] limit;

  // Negation happens one bit wider than the sample so -(-2^(DW-1)) stays positive.
  assign din_ext  = {din_i[DW-1], din_i};
  assign term     = add_i ? din_ext : (~din_ext + 1'b1);
  assign term_ext = {{(AW-DW){term[DW]}}, term};
  assign sum      = {acc_q[AW-1], acc_q} + term_ext;
  assign over     = sum[AW] ^ sum[AW-1];
  assign limit    = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};

  // NOTE: acc_d gets a default before any branch so no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    sat_o = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = over ? limit : sum[AW-1:0];
      sat_o = over;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/iq_demod_accum.sv
// Synchronous I/Q demodulator: enables the reference counter, aligns to the
// first IP rising edge and integrates +/- signed samples over N IP periods.
module iq_demod_accum
  import iq_demod_accum_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 24,
  parameter int PW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PW-1:0]         num_periods,
  input  logic                  IP,
  input  logic                  QP,
  input  logic signed [DW-1:0]  sample,
  input  logic                  sample_valid,
  output logic                  CountEnable,
  output logic                  busy,
  output logic                  done,
  output logic signed [AW-1:0]  i_acc,
  output logic signed [AW-1:0]  q_acc,
  output logic [NSW-1:0]        n_samples,
  output logic                  ovf,
  output logic                  timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic           ip_d_q;
  logic [PW-1:0]  np_q, np_d;
  logic [PW-1:0]  period_q, period_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [NSW-1:0] n_q, n_d;
  logic           ovf_q, ovf_d;
  logic           to_q, to_d;

  logic           ip_rise;
  logic           last_period;
  logic           acc_clr, acc_en;
  logic           i_sat, q_sat;
  logic [AW-1:0]  i_acc_raw, q_acc_raw;

  assign ip_rise     = IP & ~ip_d_q;
  assign last_period = ({1'b0, period_q} + {{PW{1'b0}}, 1'b1}) == {1'b0, np_q};

  always_comb begin
    state_d  = state_q;
    np_d     = np_q;
    period_d = period_q;
    timer_d  = timer_q;
    n_d      = n_q;
    ovf_d    = ovf_q | i_sat | q_sat;
    to_d     = to_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          acc_clr  = 1'b1;
          n_d      = '0;
          ovf_d    = 1'b0;
          to_d     = 1'b0;
          np_d     = num_periods;
          period_d = '0;
          timer_d  = '0;
          state_d  = (num_periods != '0) ? ST_SYNC : ST_DONE;
        end
      end
      ST_SYNC: begin
        // The aligning edge's own sample already belongs to the first period.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ip_rise) begin
          state_d  = ST_ACCUM;
          period_d = '0;
          acc_en   = sample_valid;
        end else if (timer_q == TW'(TIMEOUT)) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ip_rise && last_period) begin
          state_d = ST_DONE;
        end else begin
          if (ip_rise) period_d = period_q + 1'b1;
          acc_en = sample_valid;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (acc_en) n_d = sat_inc(n_q);
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_IDLE;
      ip_d_q   <= 1'b0;
      np_q     <= '0;
      period_q <= '0;
      timer_q  <= '0;
      n_q      <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ip_d_q   <= IP;
      np_q     <= np_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      n_q      <= n_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
    end
  end

  iq_demod_accum_sat_accum #(.AW(AW), .DW(DW)) u_i_acc (
    .clk   (Clk),
    .rst_n (Resetn),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .add_i (IP),
    .din_i (sample),
    .acc_o (i_acc_raw),
    .sat_o (i_sat)
  );

  iq_demod_accum_sat_accum #(.AW(AW), .DW(DW)) u_q_acc (
    .clk   (Clk),
    .rst_n (Resetn),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .add_i (QP),
    .din_i (sample),
    .acc_o (q_acc_raw),
    .sat_o (q_sat)
  );

  assign i_acc       = i_acc_raw;
  assign q_acc       = q_acc_raw;
  assign n_samples   = n_q;
  assign ovf         = ovf_q;
  assign timeout     = to_q;
  assign CountEnable = (state_q == ST_SYNC) || (state_q == ST_ACCUM);
  assign busy        = CountEnable;
  assign done        = (state_q == ST_DONE);

endmodule
